decoder_onehot_seq: RTL and testbench

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a timed output strobe, replacing fixed-width cascaded decoders.
- Accepts a select code through a valid/ready handshake.
- Drives the matching output line for PULSE_LEN cycles, then releases it.
- Optional auto-scan mode sweeps every line in order, for strobing banks of enables, row drivers and chip selects.

---
 rtl/decoder_onehot_seq.sv | 132 +++++++++++++
 tb/tb_decoder_onehot_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_onehot_seq.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with a timed strobe and an auto-scan sweep.
// Define OUT_ACTIVE_LOW_EN to drive y active-low (selected line 0, idle all ones).
module decoder_onehot_seq #(
  parameter int SEL_W     = 3,
  parameter int PULSE_LEN = 1,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  scan,
  output logic [(2**SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      y_idx,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(PULSE_LEN - 1);
  localparam logic [OUT_W-1:0] LINE_ONE = OUT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_SCAN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] line_q, line_d;
  logic             slot_end;
  logic             xfer;

  // Handshake: a request transfers on any clk edge where in_valid && in_ready.
  // in_ready is high only while enabled, out of reset, and either idle or in
  // the last cycle of a HOLD slot; it never rises during SCAN.
  assign slot_end = (cnt_q == '0);
  assign in_ready = rst_n && en &&
                    ((state_q == S_IDLE) || ((state_q == S_HOLD) && slot_end));
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    line_d  = line_q;
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      line_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            state_d = S_HOLD;
            cnt_d   = RELOAD;
            idx_d   = sel;
            line_d  = LINE_ONE << sel;
          end else if (scan) begin
            state_d = S_SCAN;
            cnt_d   = RELOAD;
            idx_d   = '0;
            line_d  = LINE_ONE;
          end
        end
        S_HOLD: begin
          if (!slot_end) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (xfer) begin
            cnt_d  = RELOAD;
            idx_d  = sel;
            line_d = LINE_ONE << sel;
          end else begin
            state_d = S_IDLE;
            idx_d   = '0;
            line_d  = '0;
          end
        end
        S_SCAN: begin
          // scan is only looked at once the current slot has run out.
          if (!slot_end) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (scan) begin
            cnt_d  = RELOAD;
            idx_d  = idx_q + SEL_W'(1);
            line_d = {line_q[OUT_W-2:0], line_q[OUT_W-1]};
          end else begin
            state_d = S_IDLE;
            idx_d   = '0;
            line_d  = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          line_d  = '0;
        end
      endcase
    end
  end

`ifdef OUT_ACTIVE_LOW_EN
  assign y = ~line_q;
`else
  assign y = line_q;
`endif

  assign y_idx     = idx_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Bench for decoder_onehot_seq: two instances (SEL_W=3/PULSE_LEN=3 and SEL_W=2/PULSE_LEN=1)
// share stimulus; a strobe-level model is compared every cycle, plus literal spot checks.
module tb_decoder_onehot_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic       scan = 1'b0;
  logic [2:0] sel = 3'd0;

  logic       ready_a, busy_a;
  logic [7:0] y_a;
  logic [2:0] idx_a;
  logic [1:0] dbg_a;
  logic       ready_b, busy_b;
  logic [3:0] y_b;
  logic [1:0] idx_b;
  logic [1:0] dbg_b;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

`ifdef OUT_ACTIVE_LOW_EN
  localparam logic [7:0] INV_A = 8'hFF;
  localparam logic [3:0] INV_B = 4'hF;
`else
  localparam logic [7:0] INV_A = 8'h00;
  localparam logic [3:0] INV_B = 4'h0;
`endif

  always #5 clk = ~clk;

  decoder_onehot_seq #(.SEL_W(3), .PULSE_LEN(3), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(ready_a),
    .sel(sel), .scan(scan), .y(y_a), .y_idx(idx_a), .busy(busy_a), .dbg_state(dbg_a)
  );

  decoder_onehot_seq #(.SEL_W(2), .PULSE_LEN(1), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(ready_b),
    .sel(sel[1:0]), .scan(scan), .y(y_b), .y_idx(idx_b), .busy(busy_b), .dbg_state(dbg_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=single strobe 2=sweep; left = cycles the current line still has.
  int m_mode[2] = '{0, 0};
  int m_line[2] = '{0, 0};
  int m_left[2] = '{0, 0};

  function automatic bit m_ready(input int k);
    return rst_n && en && (m_mode[k] == 0 || (m_mode[k] == 1 && m_left[k] == 1));
  endfunction

  task automatic m_step(input int k, input int plen, input int nlines, input int s);
    if (!en) m_mode[k] = 0;
    else if (m_ready(k) && in_valid) begin
      m_mode[k] = 1; m_line[k] = s; m_left[k] = plen;
    end else if (m_mode[k] == 0) begin
      if (scan) begin m_mode[k] = 2; m_line[k] = 0; m_left[k] = plen; end
    end else if (m_left[k] > 1) m_left[k]--;
    else if (m_mode[k] == 2 && scan) begin
      m_line[k] = (m_line[k] + 1) % nlines; m_left[k] = plen;
    end else m_mode[k] = 0;
  endtask

  function automatic logic [31:0] m_y(input int k);
    return (m_mode[k] != 0) ? (32'd1 << m_line[k]) : 32'd0;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin m_mode[k] = 0; m_line[k] = 0; m_left[k] = 0; end
    end else begin
      m_step(0, 3, 8, int'(sel));
      m_step(1, 1, 4, int'(sel[1:0]));
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("y_a", 32'(y_a), m_y(0) ^ 32'(INV_A));
      check("idx_a", 32'(idx_a), (m_mode[0] != 0) ? 32'(m_line[0]) : 32'd0);
      check("busy_a", 32'(busy_a), 32'(m_mode[0] != 0));
      check("ready_a", 32'(ready_a), 32'(m_ready(0)));
      check("onehot0_a", 32'($onehot0(y_a ^ INV_A)), 32'd1);
      check("y_b", 32'(y_b), m_y(1) ^ 32'(INV_B));
      check("idx_b", 32'(idx_b), (m_mode[1] != 0) ? 32'(m_line[1]) : 32'd0);
      check("busy_b", 32'(busy_b), 32'(m_mode[1] != 0));
      check("ready_b", 32'(ready_b), 32'(m_ready(1)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds a request until instance A takes it; returns 1 ns after the accepting edge.
  task automatic send(input logic [2:0] s);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    sel = s;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ready_a) got = 1'b1;
    end
    check("send_accept", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [3:0] scan_seq[7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};

  initial begin
    cmp_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk);
    check("rst_y_a", 32'(y_a), 32'(INV_A));
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_ready_a", 32'(ready_a), 32'd1);
    tick(1);

    // Single strobe sel=5, three cycles high.
    send(3'd5);
    check("single_y_c1", 32'(y_a), 32'(8'h20 ^ INV_A));
    check("single_idx_c1", 32'(idx_a), 32'd5);
    check("single_busy_c1", 32'(busy_a), 32'd1);
    tick(1);
    check("single_y_c2", 32'(y_a), 32'(8'h20 ^ INV_A));
    tick(1);
    check("single_y_c3", 32'(y_a), 32'(8'h20 ^ INV_A));
    tick(1);
    check("single_y_c4", 32'(y_a), 32'(INV_A));
    check("single_busy_c4", 32'(busy_a), 32'd0);
    tick(2);

    // Back-to-back sel=1 then sel=6 with no gap.
    send(3'd1);
    check("b2b_y_first", 32'(y_a), 32'(8'h02 ^ INV_A));
    check("b2b_ready_mid", 32'(ready_a), 32'd0);
    send(3'd6);
    check("b2b_y_second", 32'(y_a), 32'(8'h40 ^ INV_A));
    check("b2b_idx_second", 32'(idx_a), 32'd6);
    tick(5);

    // Scan on instance B (one cycle per line), dropped while line 2 is driven.
    scan = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check("scan_y_b", 32'(y_b), 32'(scan_seq[i] ^ INV_B));
      check("scan_idx_b", 32'(idx_b), 32'(i % 4));
    end
    scan = 1'b0;
    tick(1);
    check("scan_stop_y_b", 32'(y_b), 32'(INV_B));
    check("scan_stop_busy_b", 32'(busy_b), 32'd0);
    tick(5);

    // Full sweep with wrap on instance A.
    scan = 1'b1;
    tick(28);
    scan = 1'b0;
    tick(6);

    // in_valid beats scan; then en drop aborts the strobe.
    in_valid = 1'b1;
    sel = 3'd2;
    scan = 1'b1;
    tick(1);
    in_valid = 1'b0;
    scan = 1'b0;
    check("prio_y_a", 32'(y_a), 32'(8'h04 ^ INV_A));
    check("prio_y_b", 32'(y_b), 32'(4'h4 ^ INV_B));
    tick(1);
    en = 1'b0;
    #1;
    check("abort_ready_now", 32'(ready_a), 32'd0);
    tick(1);
    check("abort_y_a", 32'(y_a), 32'(INV_A));
    check("abort_busy_a", 32'(busy_a), 32'd0);
    check("abort_ready_a", 32'(ready_a), 32'd0);
    en = 1'b1;
    tick(2);

    // sel=0 strobe (0xFE when active-low).
    send(3'd0);
    check("sel0_y_a", 32'(y_a), 32'(8'h01 ^ INV_A));
    tick(3);
    check("sel0_idle_y_a", 32'(y_a), 32'(INV_A));
    tick(1);

    // Asynchronous reset in the middle of a strobe.
    send(3'd5);
    check("prereset_y_a", 32'(y_a), 32'(8'h20 ^ INV_A));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y_a", 32'(y_a), 32'(INV_A));
    check("async_rst_busy_a", 32'(busy_a), 32'd0);
    check("async_rst_ready_a", 32'(ready_a), 32'd0);
    check("async_rst_idx_a", 32'(idx_a), 32'd0);
    tick(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready_a", 32'(ready_a), 32'd1);
    tick(2);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
